// File: rtl/adc_pkg.sv
// Shared definitions for the SAR ADC conversion sequencer.
// Contents: default sizes, the phase-length type, the FSM state enum,
// reset constants and the state-to-strobe mapping.
package adc_pkg;

  localparam int unsigned MADC_DEFAULT = 17;
  localparam int unsigned WCNT_DEFAULT = 8;

  typedef logic [WCNT_DEFAULT-1:0] len_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_SAMP,
    S_COMP,
    S_UPDATE
  } state_t;

  localparam state_t     STATE_RST   = S_IDLE;
  localparam logic [3:0] STROBE_NONE = 4'b0000;

  // One-hot strobe vector {init, samp, comp, update} for a state
  function automatic logic [3:0] phase_strobe(input state_t s);
    case (s)
      S_INIT:   return 4'b1000;
      S_SAMP:   return 4'b0100;
      S_COMP:   return 4'b0010;
      S_UPDATE: return 4'b0001;
      default:  return STROBE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/adc_sequencer_if.sv
// Sequencer bus: control/config inputs, ADC phase strobes, comparator
// return path and the valid/ready result port.
// master = readout/config side plus ADC model, slave = the sequencer.
interface adc_sequencer_if
  import adc_pkg::*;
#(
  parameter int unsigned Madc = MADC_DEFAULT,
  parameter int unsigned Wcnt = WCNT_DEFAULT
);

  logic            start;
  logic            cont;
  logic [Wcnt-1:0] cfg_init_len;
  logic [Wcnt-1:0] cfg_samp_len;
  logic [Wcnt-1:0] cfg_comp_len;
  logic [Wcnt-1:0] cfg_update_len;
  logic            comp_out;
  logic            seq_init;
  logic            seq_samp;
  logic            seq_comp;
  logic            seq_update;
  logic            busy;
  logic [Madc-1:0] res_data;
  logic            res_valid;
  logic            res_ready;
  logic            overrun;

  modport master (
    output start, cont, cfg_init_len, cfg_samp_len, cfg_comp_len,
           cfg_update_len, comp_out, res_ready,
    input  seq_init, seq_samp, seq_comp, seq_update, busy,
           res_data, res_valid, overrun
  );

  modport slave (
    input  start, cont, cfg_init_len, cfg_samp_len, cfg_comp_len,
           cfg_update_len, comp_out, res_ready,
    output seq_init, seq_samp, seq_comp, seq_update, busy,
           res_data, res_valid, overrun
  );

endinterface

// File: rtl/seq_timer.sv
// Loadable phase-length down-counter.
// Ports: clk, rst (sync, active high), load/len start a new phase
// (len 0 behaves as 1), last is high during the final cycle of the phase.
module seq_timer #(
  parameter int unsigned Wcnt = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [Wcnt-1:0] len,
  output logic            last
);

  logic [Wcnt-1:0] cnt;

  // last is registered alongside cnt so it is valid in the first phase cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      last <= 1'b0;
    end else if (load) begin
      cnt  <= (len == '0) ? '0 : len - Wcnt'(1);
      last <= (len <= Wcnt'(1));
    end else if (cnt != '0) begin
      cnt  <= cnt - Wcnt'(1);
      last <= (cnt == Wcnt'(1));
    end
  end

endmodule

// File: rtl/adc_sequencer.sv
// Conversion sequencer and result collector for the SAR adc macro.
// Ports: clk, rst (sync, active high), bus (slave modport) carrying
// start/cont, phase-length config, comp_out, the four phase strobes,
// busy, and the res_data/res_valid/res_ready/overrun result port.
module adc_sequencer
  import adc_pkg::*;
#(
  parameter int unsigned Madc = MADC_DEFAULT,
  parameter int unsigned Wcnt = WCNT_DEFAULT
) (
  input logic            clk,
  input logic            rst,
  adc_sequencer_if.slave bus
);

  localparam int unsigned Kw    = (Madc > 1) ? $clog2(Madc) : 1;
  localparam logic [Kw-1:0] K_TOP = Kw'(Madc - 1);

  state_t          state;
  logic [3:0]      strobe;
  logic [Kw-1:0]   k;
  logic [Wcnt-1:0] sh_samp;
  logic [Wcnt-1:0] sh_comp;
  logic [Wcnt-1:0] sh_update;
  // Decisions for bits Madc-1..1; bit 0 is taken straight from comp_out
  logic [Madc-2:0] shift;

  logic            tmr_load;
  logic [Wcnt-1:0] tmr_len;
  logic            tmr_last;

  assign bus.seq_init   = strobe[3];
  assign bus.seq_samp   = strobe[2];
  assign bus.seq_comp   = strobe[1];
  assign bus.seq_update = strobe[0];

  // Every phase end enters a new phase, so the timer reloads on last
  assign tmr_load = (state == S_IDLE) ? (bus.start | bus.cont) : tmr_last;

  // Length of the phase entered at the next edge
  always_comb begin
    tmr_len = sh_comp;
    case (state)
      S_IDLE:   tmr_len = bus.cfg_init_len;
      S_INIT:   tmr_len = sh_samp;
      S_SAMP:   tmr_len = sh_comp;
      S_COMP:   tmr_len = (k != '0) ? sh_update : bus.cfg_init_len;
      S_UPDATE: tmr_len = sh_comp;
      default:  tmr_len = sh_comp;
    endcase
  end

  seq_timer #(
    .Wcnt (Wcnt)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .len  (tmr_len),
    .last (tmr_last)
  );

  // Phase FSM, shift register and one-entry result register
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= STATE_RST;
      strobe        <= STROBE_NONE;
      bus.busy      <= 1'b0;
      k             <= '0;
      sh_samp       <= '0;
      sh_comp       <= '0;
      sh_update     <= '0;
      shift         <= '0;
      bus.res_data  <= '0;
      bus.res_valid <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      // Handshake clears valid; a result loaded below on this edge wins
      if (bus.res_valid && bus.res_ready) bus.res_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.start || bus.cont) begin
            state     <= S_INIT;
            strobe    <= phase_strobe(S_INIT);
            bus.busy  <= 1'b1;
            k         <= K_TOP;
            sh_samp   <= bus.cfg_samp_len;
            sh_comp   <= bus.cfg_comp_len;
            sh_update <= bus.cfg_update_len;
          end
        end
        S_INIT: begin
          if (tmr_last) begin
            state  <= S_SAMP;
            strobe <= phase_strobe(S_SAMP);
          end
        end
        S_SAMP: begin
          if (tmr_last) begin
            state  <= S_COMP;
            strobe <= phase_strobe(S_COMP);
          end
        end
        S_COMP: begin
          if (tmr_last) begin
            if (k != '0) begin
              shift  <= (Madc-1)'({shift, bus.comp_out});
              k      <= k - Kw'(1);
              state  <= S_UPDATE;
              strobe <= phase_strobe(S_UPDATE);
            end else begin
              if (!bus.res_valid || bus.res_ready) begin
                bus.res_data  <= {shift, bus.comp_out};
                bus.res_valid <= 1'b1;
              end else begin
                bus.overrun <= 1'b1;
              end
              if (bus.cont) begin
                state     <= S_INIT;
                strobe    <= phase_strobe(S_INIT);
                k         <= K_TOP;
                sh_samp   <= bus.cfg_samp_len;
                sh_comp   <= bus.cfg_comp_len;
                sh_update <= bus.cfg_update_len;
              end else begin
                state    <= S_IDLE;
                strobe   <= STROBE_NONE;
                bus.busy <= 1'b0;
              end
            end
          end
        end
        S_UPDATE: begin
          if (tmr_last) begin
            state  <= S_COMP;
            strobe <= phase_strobe(S_COMP);
          end
        end
        default: begin
          state    <= S_IDLE;
          strobe   <= STROBE_NONE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sequencer.sv
// Bench for adc_sequencer: per-cycle schedule model plus directed and
// random scenarios.
module tb_adc_sequencer;
  import adc_pkg::*;

  localparam int M = MADC_DEFAULT;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;
  int   comp_mode = 0;  // 0: always 1, 1: alternate per COMP phase, 2: random

  adc_sequencer_if #(.Madc(M), .Wcnt(WCNT_DEFAULT)) bus ();

  adc_sequencer #(.Madc(M), .Wcnt(WCNT_DEFAULT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Model: a conversion is a flat list of cycles, one entry per cycle
  typedef struct {
    int ph;     // 0 init, 1 samp, 2 comp, 3 update
    int cidx;   // comparison number 0..M-1
    bit lastc;  // last cycle of a COMP phase
  } ent_t;

  ent_t         sched[$];
  ent_t         cur;
  bit           cur_v = 0;
  logic [M-1:0] acc = '0;
  logic [M-1:0] e_data = '0;
  bit           e_valid = 0;
  bit           e_ovr = 0;

  function automatic int eff(input len_t l);
    return (l == '0) ? 1 : int'(l);
  endfunction

  function automatic void build();
    int li, ls, lc, lu;
    ent_t e;
    li = eff(bus.cfg_init_len);
    ls = eff(bus.cfg_samp_len);
    lc = eff(bus.cfg_comp_len);
    lu = eff(bus.cfg_update_len);
    sched.delete();
    for (int i = 0; i < li; i++) begin e.ph = 0; e.cidx = 0; e.lastc = 0; sched.push_back(e); end
    for (int i = 0; i < ls; i++) begin e.ph = 1; e.cidx = 0; e.lastc = 0; sched.push_back(e); end
    for (int c = 0; c < M; c++) begin
      for (int j = 0; j < lc; j++) begin
        e.ph = 2; e.cidx = c; e.lastc = (j == lc - 1); sched.push_back(e);
      end
      if (c < M - 1)
        for (int j = 0; j < lu; j++) begin e.ph = 3; e.cidx = c; e.lastc = 0; sched.push_back(e); end
    end
  endfunction

  always @(posedge clk) begin
    bit fin;
    if (rst) begin
      sched.delete();
      cur_v   = 0;
      e_data  = '0;
      e_valid = 0;
      e_ovr   = 0;
    end else begin
      fin = 0;
      if (cur_v && cur.lastc) begin
        acc[M - 1 - cur.cidx] = bus.comp_out;
        if (cur.cidx == M - 1) fin = 1;
      end
      if (fin) begin
        if (!e_valid || bus.res_ready) begin
          e_data  = acc;
          e_valid = 1;
        end else begin
          e_ovr = 1;
        end
      end else if (e_valid && bus.res_ready) begin
        e_valid = 0;
      end
      if (sched.size() > 0) begin
        cur = sched.pop_front();
      end else if ((fin && bus.cont) || (!cur_v && (bus.start || bus.cont))) begin
        build();
        cur   = sched.pop_front();
        cur_v = 1;
      end else begin
        cur_v = 0;
      end
    end
  end

  // Comparator stand-in
  always @(negedge clk) begin
    case (comp_mode)
      0:       bus.comp_out = 1'b1;
      1:       bus.comp_out = cur_v && (cur.ph == 2) && (cur.cidx % 2 == 0);
      default: bus.comp_out = 1'($urandom_range(0, 1));
    endcase
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("strobes", 32'({bus.seq_init, bus.seq_samp, bus.seq_comp, bus.seq_update}),
          cur_v ? (32'h8 >> cur.ph) : 32'h0);
      chk("busy", 32'(bus.busy), 32'(cur_v));
      chk("res_valid", 32'(bus.res_valid), 32'(e_valid));
      chk("res_data", 32'(bus.res_data), 32'(e_data));
      chk("overrun", 32'(bus.overrun), 32'(e_ovr));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input int li, input int ls, input int lc, input int lu);
    bus.cfg_init_len   = len_t'(li);
    bus.cfg_samp_len   = len_t'(ls);
    bus.cfg_comp_len   = len_t'(lc);
    bus.cfg_update_len = len_t'(lu);
  endtask

  // Called at a negedge; returns at the negedge of cycle 1
  task automatic start_conv();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Advance until res_valid; n holds the current cycle number
  task automatic wait_valid(input int n0, output int n);
    n = n0;
    while (!bus.res_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.res_valid) chk("res_valid_timeout", 32'(bus.res_valid), 32'h1);
  endtask

  initial begin
    int n;
    int hs;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.cont = 1'b0;
    bus.res_ready = 1'b1;
    set_cfg(1, 1, 1, 1);
    @(negedge clk);
    chk_en = 1;
    tick(2);
    chk("rst_strobes", 32'({bus.seq_init, bus.seq_samp, bus.seq_comp, bus.seq_update}), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_valid", 32'(bus.res_valid), 32'h0);
    chk("rst_data", 32'(bus.res_data), 32'h0);
    chk("rst_overrun", 32'(bus.overrun), 32'h0);
    rst = 1'b0;
    tick(2);

    // All lengths 1, comparator always 1
    comp_mode = 0;
    start_conv();
    wait_valid(1, n);
    chk("t1_T", 32'(n), 32'd36);
    chk("t1_data", 32'(bus.res_data), 32'h1FFFF);
    tick(3);

    // Lengths 3/5/2/4, alternating decisions
    comp_mode = 1;
    set_cfg(3, 5, 2, 4);
    start_conv();
    wait_valid(1, n);
    chk("t2_T", 32'(n), 32'd107);
    chk("t2_data", 32'(bus.res_data), 32'h15555);
    tick(3);

    // Output register full: second result dropped
    set_cfg(1, 1, 1, 1);
    bus.res_ready = 1'b0;
    comp_mode = 0;
    start_conv();
    wait_valid(1, n);
    chk("t3_first_T", 32'(n), 32'd36);
    comp_mode = 1;
    tick(2);
    start_conv();
    tick(40);
    chk("t3_held_data", 32'(bus.res_data), 32'h1FFFF);
    chk("t3_overrun", 32'(bus.overrun), 32'h1);
    start_conv();
    tick(34);
    bus.res_ready = 1'b1;  // cycle 35: ready coincides with the finish
    tick(1);
    chk("t3_third_data", 32'(bus.res_data), 32'h15555);
    chk("t3_third_valid", 32'(bus.res_valid), 32'h1);
    chk("t3_overrun_kept", 32'(bus.overrun), 32'h1);
    tick(1);
    chk("t3_consumed", 32'(bus.res_valid), 32'h0);

    // Continuous mode, three back-to-back conversions
    comp_mode = 2;
    bus.cont = 1'b1;
    @(negedge clk);
    hs = 0;
    n = 1;
    while (n <= 112) begin
      if (bus.res_valid && bus.res_ready) hs++;
      if (n == 36) begin
        chk("t4_init_at_T", 32'(bus.seq_init), 32'h1);
        chk("t4_busy_at_T", 32'(bus.busy), 32'h1);
      end
      if (n == 80) bus.cont = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("t4_handshakes", 32'(hs), 32'd3);
    chk("t4_idle_after", 32'(bus.busy), 32'h0);

    // Reset during the fifth COMP phase
    comp_mode = 0;
    start_conv();
    tick(10);
    chk("t5_in_comp", 32'(bus.seq_comp), 32'h1);
    rst = 1'b1;
    tick(1);
    chk("t5_strobes", 32'({bus.seq_init, bus.seq_samp, bus.seq_comp, bus.seq_update}), 32'h0);
    chk("t5_busy", 32'(bus.busy), 32'h0);
    chk("t5_valid", 32'(bus.res_valid), 32'h0);
    chk("t5_overrun", 32'(bus.overrun), 32'h0);
    rst = 1'b0;
    tick(2);
    start_conv();
    wait_valid(1, n);
    chk("t5_after_T", 32'(n), 32'd36);
    chk("t5_after_data", 32'(bus.res_data), 32'h1FFFF);
    tick(3);

    // Start during SAMP and config changes mid-conversion are ignored
    comp_mode = 1;
    set_cfg(3, 5, 2, 4);
    start_conv();
    tick(4);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    set_cfg(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
            int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
    wait_valid(6, n);
    chk("t6_T", 32'(n), 32'd107);
    chk("t6_data", 32'(bus.res_data), 32'h15555);
    tick(3);

    // Random traffic against the model
    comp_mode = 2;
    for (int c = 0; c < 2500; c++) begin
      bus.start = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) bus.cont = ~bus.cont;
      bus.res_ready = 1'($urandom_range(0, 1));
      set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    bus.cont = 1'b0;
    bus.start = 1'b0;
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_sequencer.md
# adc_sequencer

Conversion sequencer and result collector for the SAR `adc` macro. Generates the `seq_init`/`seq_samp`/`seq_comp`/`seq_update` phase strobes for one conversion, runs `Madc` comparison cycles, and captures `comp_out` MSB-first into a `Madc`-bit raw code. The code is presented on a one-entry valid/ready output register. The block sits in the digital periphery between the readout/config logic and the `adc` instance.

## Interface
- `Madc`, 17: comparison cycles per conversion; equals the `adc` parameter.
- `Wcnt`, 8: width of each phase-length field.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle conversion request; ignored while `busy`=1
- `cont`  in  1  continuous mode: re-enter INIT immediately after the last comparison
- `cfg_init_len`, `cfg_samp_len`, `cfg_comp_len`, `cfg_update_len`  in  `Wcnt` each  phase lengths in cycles; value 0 is treated as 1
- `comp_out`  in  1  comparator decision from `adc`
- `seq_init`, `seq_samp`, `seq_comp`, `seq_update`  out  1 each  phase strobes to `adc`; registered, glitch-free
- `busy`  out  1  conversion in progress (any state other than IDLE)
- `res_data`  out  `Madc`  raw code, first decision at bit `Madc-1`
- `res_valid`  out  1  `res_data` holds an unconsumed result
- `res_ready`  in  1  consumer accepts `res_data` when `res_valid`&&`res_ready`
- `overrun`  out  1  sticky; a finished result was dropped because the output register was full

## Operation
- States: IDLE, INIT, SAMP, COMP, UPDATE.
- IDLE -> INIT when `start` (or `cont`) is sampled high. All four `cfg_*_len` values are latched into shadow registers at that edge and are held constant for the whole conversion.
- INIT (`seq_init`=1) runs Li cycles -> SAMP (`seq_samp`=1) runs Ls cycles -> COMP.
- Bit index `k` counts `Madc-1` down to 0 and is loaded with `Madc-1` on entry to INIT.
- COMP (`seq_comp`=1) runs Lc cycles. On the edge leaving COMP, `comp_out` is written into shift bit `k`.
  - If `k`>0: go to UPDATE (`seq_update`=1, Lu cycles), decrement `k`, then return to COMP.
  - If `k`==0: the conversion is finished; go to INIT if `cont`=1, else IDLE.
- A conversion therefore has `Madc` COMP phases and `Madc-1` UPDATE phases.
- Exactly one `seq_*` is high in any non-IDLE cycle; none are high in IDLE.
- Result hand-off on the finishing edge:
  - If `res_valid`=0, or `res_ready`=1 in the same cycle: load `res_data` and set `res_valid`=1.
  - Otherwise: keep the old data, discard the new result, set `overrun`=1.
- `res_valid` clears on handshake unless a new result is loaded on the same edge.
- `overrun` clears only on `rst`.
- `start` while `busy`: ignored, no effect.

## Timing
- Reset values: all `seq_*`=0, `busy`=0, `res_valid`=0, `res_data`=0, `overrun`=0, state IDLE.
- `rst` mid-conversion: the next cycle is IDLE with all outputs at reset values; the partial result is discarded.
- Let `start` be sampled at edge 0.
  - `seq_init` is high in cycles 1..Li.
  - `seq_samp` is high in cycles Li+1..Li+Ls.
  - The first `seq_comp` starts in cycle Li+Ls+1.
- `res_valid` rises in cycle T = Li+Ls+Madc·Lc+(Madc-1)·Lu+1. For all lengths =1 and `Madc`=17, T=36.
- In continuous mode `seq_init` restarts in cycle T, back-to-back with no IDLE cycle. `busy` stays high.
- Phase lengths: counter width `Wcnt`, maximum 2^Wcnt−1 cycles per phase.

## Structure
- Shared package `adc_pkg`:
  - state enum.
  - `Madc` default.
  - phase-length typedef (`Wcnt` bits).
  - reset constants.
- One sub-module, `seq_timer`: a loadable down-counter that maps length 0 to 1 and emits a `last` pulse on the final cycle of each phase. The FSM loads it on every phase entry.

## Test plan
- Reset, then `start` with all lengths 1 and `comp_out` tied to 1 -> strobe order INIT, SAMP, then COMP/UPDATE alternating (17 COMP, 16 UPDATE); `res_data`=0x1FFFF; `res_valid` high in cycle 36.
- Lengths 3/5/2/4, with `comp_out` driven alternating 1,0,… per COMP phase -> `res_data`=0x15555; strobe widths exactly 3/5/2/4 cycles; T=3+5+34+64+1=107.
- `res_ready`=0, two conversions -> first code held; second dropped; `overrun`=1. Then `res_ready`=1 together with a third finish -> third code loaded, no extra overrun event.
- `cont`=1 for 3 conversions -> INIT follows the last COMP with no gap; `busy` stays high; three `res_valid` handshakes.
- `rst` asserted in the 5th COMP phase -> all outputs 0 the next cycle; `res_valid` stays 0; a following `start` produces a correct full result.
- `start` pulsed during SAMP, and any `cfg_*_len` changed mid-conversion -> no restart, and the current conversion's timing is unchanged.
